// File: rtl/skinny_sbox_dom_pkg.sv
// Shared constants, FSM state type and the unmasked reference function
// for the first-order DOM-masked SKINNY-128 inverse 8-bit S-box.
package skinny_sbox_dom_pkg;

    localparam int SBOX_LEVELS = 4;
    localparam int CNT_W       = 2;

    // Last BUSY count: level 4 is registered on the edge that leaves BUSY.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SBOX_LEVELS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Unmasked inverse S-box, used by checkers as the golden function.
    function automatic logic [7:0] inv_sbox8(input logic [7:0] o);
        logic [7:0] b;
        b       = 8'h00;
        b[2]    = ~(o[3] | o[1]) ^ o[0];
        b[3]    = ~(o[7] | o[6]) ^ o[4];
        b[7]    = ~(o[2] | o[7]) ^ o[1];
        b[5]    = ~(o[6] | o[5]) ^ o[7];
        b[1]    = ~(o[5] | b[3]) ^ o[3];
        b[0]    = ~(b[3] | b[2]) ^ o[5];
        b[6]    = ~(b[2] | b[1]) ^ o[2];
        b[4]    = ~(b[7] | b[6]) ^ o[6];
        return b;
    endfunction

endpackage

// File: rtl/skinny_inv_sbox8_dom1_hs_gadget.sv
// One first-order DOM-Indep masked nor-xor gadget: f = nor(x,y) ^ z.
// Index [1] is share 1, index [0] is share 0. Inner and cross terms are
// registered separately before being combined, so the two shares of x or y
// never meet in the same combinational cone.
module dom1_nor_xor_gadget (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] x,
    input  logic [1:0] y,
    input  logic [1:0] z,
    input  logic       r,
    output logic [1:0] f
);

    logic inner1_r;
    logic inner0_r;
    logic cross1_r;
    logic cross0_r;

    // Register the two inner-domain terms and the two refreshed cross terms.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inner1_r <= 1'b0;
            inner0_r <= 1'b0;
            cross1_r <= 1'b0;
            cross0_r <= 1'b0;
        end else begin
            inner1_r <= (~x[1] & ~y[1]) ^ z[1];
            inner0_r <= (x[0] & y[0]) ^ z[0];
            cross1_r <= (~x[1] & y[0]) ^ r;
            cross0_r <= (~y[1] & x[0]) ^ r;
        end
    end

    assign f = {cross1_r ^ inner1_r, cross0_r ^ inner0_r};

endmodule

// File: rtl/skinny_inv_sbox8_dom1_hs.sv
// First-order DOM masked SKINNY-128 inverse 8-bit S-box with valid/ready
// handshakes on both sides. One evaluation in flight; 4 gadget levels,
// one clock each. Operands are held in registers for the whole computation.
// Optional build macro SKINNY_INV_SBOX_CLEAR_EN: zero the operand registers
// on the output handshake so no stale shares linger in the datapath.
module skinny_inv_sbox8_dom1_hs
    import skinny_sbox_dom_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] si1,
    input  logic [7:0] si0,
    input  logic [7:0] r,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] bo1,
    output logic [7:0] bo0,
    output logic       out_valid,
    input  logic       out_ready
);

    state_e           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             in_ready_r;
    logic             out_valid_r;

    logic [7:0]       op1_r;
    logic [7:0]       op0_r;
    logic [7:0]       opr_r;

    logic [1:0]       o_s  [0:7];
    logic [1:0]       bf_s [0:7];
    logic [7:0]       bo1_s;
    logic [7:0]       bo0_s;

    // Control FSM with registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        state_r    <= BUSY;
                        cnt_r      <= {CNT_W{1'b0}};
                        in_ready_r <= 1'b0;
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end
                BUSY: begin
                    cnt_r <= cnt_r + 2'd1;
                    if (cnt_r == CNT_LAST) begin
                        state_r     <= DONE;
                        out_valid_r <= 1'b1;
                    end else begin
                        out_valid_r <= 1'b0;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_r     <= IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end else begin
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    cnt_r       <= {CNT_W{1'b0}};
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Operand register: capture shares and mask on accept, hold until consumed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op1_r <= 8'h00;
            op0_r <= 8'h00;
            opr_r <= 8'h00;
        end else if (in_valid && in_ready_r) begin
            op1_r <= si1;
            op0_r <= si0;
            opr_r <= r;
`ifdef SKINNY_INV_SBOX_CLEAR_EN
        end else if (out_valid_r && out_ready) begin
            op1_r <= 8'h00;
            op0_r <= 8'h00;
            opr_r <= 8'h00;
`endif
        end else begin
            op1_r <= op1_r;
            op0_r <= op0_r;
            opr_r <= opr_r;
        end
    end

    // Pair up operand share bits and split gadget outputs back into shares.
    always_comb begin
        bo1_s = 8'h00;
        bo0_s = 8'h00;
        for (int i = 0; i < 8; i++) begin
            o_s[i]   = {op1_r[i], op0_r[i]};
            bo1_s[i] = bf_s[i][1];
            bo0_s[i] = bf_s[i][0];
        end
    end

    // Level 1
    dom1_nor_xor_gadget u_b2 (.clk(clk), .rst_n(rst_n), .x(o_s[3]),  .y(o_s[1]),  .z(o_s[0]), .r(opr_r[0]), .f(bf_s[2]));
    dom1_nor_xor_gadget u_b3 (.clk(clk), .rst_n(rst_n), .x(o_s[7]),  .y(o_s[6]),  .z(o_s[4]), .r(opr_r[1]), .f(bf_s[3]));
    dom1_nor_xor_gadget u_b7 (.clk(clk), .rst_n(rst_n), .x(o_s[2]),  .y(o_s[7]),  .z(o_s[1]), .r(opr_r[2]), .f(bf_s[7]));
    dom1_nor_xor_gadget u_b5 (.clk(clk), .rst_n(rst_n), .x(o_s[6]),  .y(o_s[5]),  .z(o_s[7]), .r(opr_r[3]), .f(bf_s[5]));
    // Level 2
    dom1_nor_xor_gadget u_b1 (.clk(clk), .rst_n(rst_n), .x(o_s[5]),  .y(bf_s[3]), .z(o_s[3]), .r(opr_r[4]), .f(bf_s[1]));
    dom1_nor_xor_gadget u_b0 (.clk(clk), .rst_n(rst_n), .x(bf_s[3]), .y(bf_s[2]), .z(o_s[5]), .r(opr_r[5]), .f(bf_s[0]));
    // Level 3
    dom1_nor_xor_gadget u_b6 (.clk(clk), .rst_n(rst_n), .x(bf_s[2]), .y(bf_s[1]), .z(o_s[2]), .r(opr_r[6]), .f(bf_s[6]));
    // Level 4
    dom1_nor_xor_gadget u_b4 (.clk(clk), .rst_n(rst_n), .x(bf_s[7]), .y(bf_s[6]), .z(o_s[6]), .r(opr_r[7]), .f(bf_s[4]));

    assign bo1       = bo1_s;
    assign bo0       = bo0_s;
    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;

endmodule
